// File: rtl/ldm_stm_sequencer_pkg.sv
// ============================================================================
//  Module   : ldm_pkg
//  Brief    : Shared types and constants for the LDM/STM block-transfer sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldm_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_BASEWB = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Addressing mode is the {P, U} bit pair of the instruction
    typedef enum logic [1:0] {
        AM_DA = 2'b00,
        AM_IA = 2'b01,
        AM_DB = 2'b10,
        AM_IB = 2'b11
    } amode_t;

    localparam logic [3:0] PC_IDX     = 4'd15;
    localparam int         WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/ldm_stm_sequencer_if.sv
// ============================================================================
//  Module   : ldm_stm_sequencer_if
//  Brief    : Execute request, register-file and data-memory signals of the sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ldm_stm_sequencer_if #(
    parameter int AW   = 32,
    parameter int NREG = 16
);
    // Execute request
    logic            start;
    logic            load;
    logic            up;
    logic            pre;
    logic            wb;
    logic [3:0]      rn;
    logic [NREG-1:0] reglist;
    logic [AW-1:0]   base;
    logic            busy;
    logic            done;

    // Register file
    logic [3:0]      ra;
    logic [AW-1:0]   rd_data;
    logic            rf_we;
    logic [3:0]      rf_wa;
    logic [AW-1:0]   rf_wd;
    logic            pc_we;
    logic [AW-1:0]   pc_wd;

    // Data memory
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [AW-1:0]   mem_wd;
    logic [AW-1:0]   mem_rdata;
    logic            mem_ready;

    modport master (
        output start, load, up, pre, wb, rn, reglist, base,
        output rd_data, mem_rdata, mem_ready,
        input  busy, done, ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd,
        input  mem_req, mem_we, mem_addr, mem_wd
    );

    modport slave (
        input  start, load, up, pre, wb, rn, reglist, base,
        input  rd_data, mem_rdata, mem_ready,
        output busy, done, ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd,
        output mem_req, mem_we, mem_addr, mem_wd
    );

endinterface

`default_nettype wire

// File: rtl/ldm_stm_sequencer_reglist_ffs.sv
// ============================================================================
//  Module   : reglist_ffs
//  Brief    : Find lowest set bit of a register list (index plus valid flag)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reglist_ffs #(
    parameter int NREG = 16,
    parameter int IW   = $clog2(NREG)
) (
    input  wire logic [NREG-1:0] i_list,
    output logic      [IW-1:0]   o_idx,
    output logic                 o_valid
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx   = IW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
// ============================================================================
//  Module   : ldm_stm_sequencer
//  Brief    : Multi-cycle LDM/STM sequencer: one memory access per listed
//             register, lowest first, then optional base writeback
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldm_stm_sequencer
    import ldm_pkg::*;
#(
    parameter int AW   = 32,
    parameter int NREG = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ldm_stm_sequencer_if.slave bus
);

    localparam int CW = $clog2(NREG + 1);
    localparam int SW = CW + 2;

    state_t          r_state;
    state_t          w_next;
    logic            r_load;
    logic            r_wb;
    logic            r_supp;
    logic [3:0]      r_rn;
    logic [NREG-1:0] r_list;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_wbval;

    logic [CW-1:0]   w_cnt;
    logic [AW-1:0]   w_span;
    logic [AW-1:0]   w_base_up;
    logic [AW-1:0]   w_base_dn;
    logic [AW-1:0]   w_start_addr;
    logic [AW-1:0]   w_wbval;
    logic [NREG-1:0] w_list_clr;
    logic [3:0]      w_r;
    logic            w_rvalid;
    logic            w_last;
    logic            w_step;
    logic            w_accept;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt = w_cnt + CW'(bus.reglist[i]);
        end
    end

    // 4N fits in SW bits and is zero-extended to the address width
    always_comb begin
        w_span         = '0;
        w_span[SW-1:0] = {w_cnt, 2'b00};
    end

    assign w_base_up = bus.base + w_span;
    assign w_base_dn = bus.base - w_span;
    assign w_wbval   = bus.up ? w_base_up : w_base_dn;

    always_comb begin
        case (amode_t'({bus.pre, bus.up}))
            AM_IA:   w_start_addr = bus.base;
            AM_IB:   w_start_addr = bus.base + AW'(WORD_BYTES);
            AM_DA:   w_start_addr = w_base_dn + AW'(WORD_BYTES);
            default: w_start_addr = w_base_dn;
        endcase
    end

    reglist_ffs #(
        .NREG (NREG)
    ) u_ffs (
        .i_list  (r_list),
        .o_idx   (w_r),
        .o_valid (w_rvalid)
    );

    always_comb begin
        w_list_clr      = r_list;
        w_list_clr[w_r] = 1'b0;
    end

    assign w_last   = (w_list_clr == '0);
    assign w_step   = (r_state == S_XFER) && w_rvalid && bus.mem_ready;
    assign w_accept = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_wb    <= 1'b0;
            r_supp  <= 1'b0;
            r_rn    <= '0;
            r_list  <= '0;
            r_addr  <= '0;
            r_wbval <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_load  <= bus.load;
                r_wb    <= bus.wb;
                // A loaded base register keeps the loaded value, not the writeback
                r_supp  <= bus.load && bus.reglist[bus.rn];
                r_rn    <= bus.rn;
                r_list  <= bus.reglist;
                r_addr  <= w_start_addr;
                r_wbval <= w_wbval;
            end else if (w_step) begin
                r_list  <= w_list_clr;
                r_addr  <= r_addr + AW'(WORD_BYTES);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.ra       = '0;
        bus.rf_we    = 1'b0;
        bus.rf_wa    = '0;
        bus.rf_wd    = '0;
        bus.pc_we    = 1'b0;
        bus.pc_wd    = '0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_cnt != '0) begin
                        w_next = S_XFER;
                    end else if (bus.wb) begin
                        w_next = S_BASEWB;
                    end else begin
                        w_next = S_FIN;
                    end
                end
            end

            S_XFER: begin
                bus.busy = 1'b1;
                if (w_rvalid) begin
                    bus.mem_req  = 1'b1;
                    bus.mem_addr = r_addr;
                    bus.mem_we   = !r_load;
                    // Register-file writes happen on negedge, so they follow mem_ready directly
                    if (!r_load) begin
                        bus.ra     = w_r;
                        bus.mem_wd = bus.rd_data;
                    end else if (w_r == PC_IDX) begin
                        bus.pc_we = bus.mem_ready;
                        bus.pc_wd = {bus.mem_rdata[AW-1:2], 2'b00};
                    end else begin
                        bus.rf_we = bus.mem_ready;
                        bus.rf_wa = w_r;
                        bus.rf_wd = bus.mem_rdata;
                    end
                    if (bus.mem_ready && w_last) begin
                        w_next = (r_wb && !r_supp) ? S_BASEWB : S_FIN;
                    end
                end else begin
                    w_next = S_FIN;
                end
            end

            S_BASEWB: begin
                bus.busy = 1'b1;
                if (r_rn == PC_IDX) begin
                    bus.pc_we = 1'b1;
                    bus.pc_wd = r_wbval;
                end else begin
                    bus.rf_we = 1'b1;
                    bus.rf_wa = r_rn;
                    bus.rf_wd = r_wbval;
                end
                w_next = S_FIN;
            end

            S_FIN: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
// ============================================================================
//  Module   : tb_ldm_stm_sequencer
//  Brief    : Directed scoreboard bench for the LDM/STM sequencer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldm_stm_sequencer;

    localparam int K_ST   = 0;
    localparam int K_LD   = 1;
    localparam int K_RF   = 2;
    localparam int K_PC   = 3;
    localparam int K_NONE = 99;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        reset;
    ev_t         q[$];
    int          errors;
    int          checks;
    int          xfers_done;
    int          stall_idx;
    int          stall_left;
    logic        hold_valid;
    logic [31:0] hold_addr;
    logic [31:0] hold_wd;
    logic        last_done;
    logic        last_busy;

    ldm_stm_sequencer_if #(.AW(32), .NREG(16)) bus ();

    ldm_stm_sequencer #(
        .AW   (32),
        .NREG (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memval(logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    function automatic logic [31:0] regval(logic [3:0] r);
        return 32'hC0DE_0000 | {28'd0, r};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(int k, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        if (q.size() == 0) begin
            e.kind = K_NONE;
            e.addr = '0;
            e.data = '0;
        end else begin
            e = q.pop_front();
        end
        return e;
    endfunction

    // Reference model: expected memory and register writes for one instruction
    task automatic expect_op(logic ld, logic up, logic pre, logic wb,
                             logic [3:0] rn, logic [15:0] list, logic [31:0] base);
        int          n;
        logic [31:0] span;
        logic [31:0] a;
        n = 0;
        for (int i = 0; i < 16; i++) if (list[i]) n++;
        span = n * 4;
        case ({pre, up})
            2'b01:   a = base;
            2'b11:   a = base + 4;
            2'b00:   a = base - span + 4;
            default: a = base - span;
        endcase
        for (int r = 0; r < 16; r++) begin
            if (list[r]) begin
                if (ld) begin
                    push(K_LD, a, 32'd0);
                    if (r == 15) push(K_PC, 32'd15, memval(a) & 32'hFFFF_FFFC);
                    else         push(K_RF, r, memval(a));
                end else begin
                    push(K_ST, a, regval(r[3:0]));
                end
                a = a + 4;
            end
        end
        if (wb && !(ld && list[rn])) begin
            if (rn == 4'd15) push(K_PC, 32'd15, up ? base + span : base - span);
            else             push(K_RF, {28'd0, rn}, up ? base + span : base - span);
        end
    endtask

    task automatic sample();
        ev_t e;
        if (hold_valid) begin
            check("hold_addr", bus.mem_addr, hold_addr);
            check("hold_wd", bus.mem_wd, hold_wd);
        end
        if (bus.mem_req && bus.mem_ready) begin
            e = pop_ev();
            check("mem_kind", bus.mem_we ? K_ST : K_LD, e.kind);
            check("mem_addr", bus.mem_addr, e.addr);
            if (bus.mem_we) check("mem_wd", bus.mem_wd, e.data);
        end
        if (bus.rf_we) begin
            e = pop_ev();
            check("rf_kind", K_RF, e.kind);
            check("rf_wa", {28'd0, bus.rf_wa}, e.addr);
            check("rf_wd", bus.rf_wd, e.data);
        end
        if (bus.pc_we) begin
            e = pop_ev();
            check("pc_kind", K_PC, e.kind);
            check("pc_wd", bus.pc_wd, e.data);
        end
        last_done  = bus.done;
        last_busy  = bus.busy;
        hold_valid = bus.mem_req && !bus.mem_ready;
        hold_addr  = bus.mem_addr;
        hold_wd    = bus.mem_wd;
        if (bus.mem_req) begin
            if (bus.mem_ready)       xfers_done++;
            else if (stall_left > 0) stall_left--;
        end
    endtask

    // Called at a negedge: model memory/register file, sample, advance one cycle
    task automatic cyc();
        bus.mem_ready = !(bus.mem_req && xfers_done == stall_idx && stall_left > 0);
        bus.mem_rdata = memval(bus.mem_addr);
        bus.rd_data   = regval(bus.ra);
        #1;
        sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_ctrl"}, {26'd0, bus.busy, bus.done, bus.rf_we, bus.pc_we,
                               bus.mem_req, bus.mem_we}, 32'd0);
        check({tag, "_data"}, {28'd0, bus.ra} | {28'd0, bus.rf_wa} | bus.rf_wd |
                              bus.pc_wd | bus.mem_addr | bus.mem_wd, 32'd0);
    endtask

    task automatic drive_req(logic ld, logic up, logic pre, logic wb,
                             logic [3:0] rn, logic [15:0] list, logic [31:0] base);
        bus.load    = ld;
        bus.up      = up;
        bus.pre     = pre;
        bus.wb      = wb;
        bus.rn      = rn;
        bus.reglist = list;
        bus.base    = base;
        bus.start   = 1'b1;
    endtask

    task automatic run_op(string tag, logic ld, logic up, logic pre, logic wb,
                          logic [3:0] rn, logic [15:0] list, logic [31:0] base,
                          int exp_lat);
        int lat;
        lat        = -1;
        xfers_done = 0;
        hold_valid = 1'b0;
        expect_op(ld, up, pre, wb, rn, list, base);
        drive_req(ld, up, pre, wb, rn, list, base);
        cyc();
        check({tag, "_start_busy"}, {31'd0, last_busy}, 32'd0);
        bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            cyc();
            if (last_done) begin
                lat = n;
                break;
            end
            check({tag, "_busy"}, {31'd0, last_busy}, 32'd1);
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pending"}, q.size(), 0);
        q.delete();
        cyc();
        check({tag, "_done_pulse"}, {30'd0, last_done, last_busy}, 32'd0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        xfers_done  = 0;
        stall_idx   = -1;
        stall_left  = 0;
        hold_valid  = 1'b0;
        last_done   = 1'b0;
        last_busy   = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.load    = 1'b0;
        bus.up      = 1'b0;
        bus.pre     = 1'b0;
        bus.wb      = 1'b0;
        bus.rn      = '0;
        bus.reglist = '0;
        bus.base    = '0;
        bus.rd_data = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b1;

        @(negedge clk);
        cyc();
        cyc();
        check_idle("reset");
        reset = 1'b0;
        cyc();
        check_idle("idle");

        // STM IA with writeback: 4 stores, base <- 0x110
        run_op("stm_ia", 1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 16'h000F, 32'h0000_0100, 6);
        // LDM DB with R15: PC reload, no writeback
        run_op("ldm_db_pc", 1'b1, 1'b0, 1'b1, 1'b0, 4'd13, 16'h8003, 32'h0000_0200, 4);
        // LDM with base in list: writeback suppressed
        run_op("ldm_rn_in_list", 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0004, 32'h0000_0500, 2);
        // STM DA with base R15: writeback through the PC port
        run_op("stm_da_pcwb", 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'h0011, 32'h0000_0800, 4);
        // Empty list, decrement: only the base writeback
        run_op("empty", 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0000, 32'h0000_0040, 2);

        // Three wait states on the second transfer
        stall_idx  = 1;
        stall_left = 3;
        run_op("wait", 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0070, 32'h0000_0300, 8);
        check("wait_consumed", stall_left, 0);
        stall_idx  = -1;

        // Reset during the second of four transfers
        xfers_done = 0;
        hold_valid = 1'b0;
        expect_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00F0, 32'h0000_0400);
        drive_req(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00F0, 32'h0000_0400);
        cyc();
        bus.start = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_idle("rst_mid");
        check("rst_pending", q.size(), 5);
        q.delete();
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_idle("rst_after");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle sequencer for ARM load/store-multiple (LDM/STM) instructions in the pipelined core. It takes a decoded block-transfer request from Execute and stalls the pipeline while it steps through the 16-bit register list, lowest register first. For each register it drives the register-file read or write port and one data-memory access, then optionally writes back the updated base register.

## Interface
Parameters:
- AW, 32, address/data width
- NREG, 16, register-list width (R0..R15)

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  request strobe from Execute; accepted only in IDLE
- load  in  1  1 = LDM, 0 = STM
- up  in  1  U bit: 1 = increment, 0 = decrement
- pre  in  1  P bit: 1 = before, 0 = after
- wb  in  1  W bit: base writeback
- rn  in  4  base register index
- reglist  in  16  register list; bit i = Ri
- base  in  32  value of Rn, captured at start
- busy  out  1  pipeline stall request
- done  out  1  one-cycle completion pulse
- ra  out  4  register-file read address (STM source register)
- rd_data  in  32  register-file read data for ra
- rf_we  out  1  register-file write enable (write-address port)
- rf_wa  out  4  register-file write address
- rf_wd  out  32  register-file write data
- pc_we  out  1  load to R15: redirect the PC
- pc_wd  out  32  new PC value
- mem_req  out  1  memory access valid
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (bits [1:0] = 0)
- mem_wd  out  32  store data
- mem_rdata  in  32  load data
- mem_ready  in  1  access completes at this posedge

## Operation
- States are IDLE, XFER, BASEWB and FIN.
- **IDLE:** on `start`, latch load, up, pre, wb, rn, reglist and base. Compute N = popcount(reglist), then the start address:
  - IA: base
  - IB: base+4
  - DA: base−4N+4
  - DB: base−4N
- **IDLE transitions:** go to XFER if N>0. Otherwise go to BASEWB if wb, else FIN.
- **XFER:** current register r = lowest set bit of the remaining list.
  - Drive mem_req=1 and mem_addr = current address, with mem_we = !load.
  - STM: ra = r and mem_wd = rd_data. R15 reads as PC+8, which the register file already supplies.
  - LDM, r≠15: rf_we = mem_ready, rf_wa = r, rf_wd = mem_rdata.
  - LDM, r=15: instead pc_we = mem_ready and pc_wd = {mem_rdata[31:2], 2'b00}.
  - When mem_ready is sampled high: clear bit r and add 4 to the address (always ascending).
  - On the last bit: go to BASEWB if wb and not suppressed, else FIN.
- **Writeback suppression:** suppressed when load=1 and reglist[rn]=1; the loaded value wins.
- **BASEWB:** one cycle with rf_we=1, rf_wa=rn, rf_wd = up ? base+4N : base−4N. Then go to FIN.
- **FIN:** done=1 and busy=0. Always returns to IDLE; start is ignored in FIN.
- Arithmetic is mod 2^32. N ranges 0..16, so 4N needs 7 bits and is zero-extended.
- rn=15 with wb=1 writes via pc_we/pc_wd instead of rf_we.

## Timing
- **Reset values:** state=IDLE; busy, done, rf_we, pc_we, mem_req, mem_we = 0; ra, rf_wa, rf_wd, pc_wd, mem_addr, mem_wd = 0.
- **Start:** start is sampled at posedge in IDLE; busy=1 from the next cycle through the last BASEWB/XFER cycle.
- **Combinational outputs:** rf_we, pc_we and rf_wd are combinational in XFER, because the register file writes on negedge, within the same cycle as mem_ready.
- **Memory handshake:** mem_addr, mem_we and mem_wd are held stable while mem_req=1 and mem_ready=0.
- **Latency** with mem_ready tied high: 1 + N + (wb&&!suppressed) + 1 cycles from start to the done cycle.
- **Reset mid-operation:** the next posedge returns to IDLE with no further register or memory writes. Completed transfers are not undone.
- **Simultaneous events:** start while busy or in FIN is dropped, not queued. The upstream hazard unit guarantees start only when busy=0.

## Structure
- Shared package `ldm_pkg`:
  - state enum (IDLE, XFER, BASEWB, FIN)
  - addressing-mode encoding {pre, up}
  - constant PC_IDX = 4'd15
- Sub-module `reglist_ffs`: combinational 16-bit find-lowest-set-bit. Outputs a 4-bit index and a valid flag.
- Popcount is inline.
- Everything else is in one always block plus combinational output logic.

## Test plan
- **STM IA:** base=0x100, reglist=0x000F, wb=1, mem_ready=1 → stores R0..R3 to 0x100/104/108/10C, then rf_we with rn←0x110; done at cycle 6.
- **LDM DB, R15 in list:** base=0x200, reglist=0x8003, wb=0 → loads 0x1F4→R0, 0x1F8→R1, 0x1FC→pc_we; no BASEWB.
- **LDM with rn=2 in list:** reglist=0x0004, wb=1 → R2 gets memory data; no base writeback cycle.
- **Wait states:** mem_ready low for 3 cycles on the second transfer → address and data are held, no duplicate rf_we, and done is delayed by 3 cycles.
- **Empty list:** reglist=0, wb=1, up=0, base=0x40 → no mem_req, Rn←0x40, done 2 cycles after start.
- **Reset during XFER:** reset on the 2nd of 4 transfers → next cycle IDLE, all outputs 0, and no subsequent writes.
